mem_load_regfile: RTL and testbench

//  Parametrised successor to the single-register memory-to-register path.

---
 rtl/mem_load_regfile.sv | 111 +++++++++++
 tb/tb_mem_load_regfile.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_load_regfile.sv
// IR, register file and a req/ack load sequencer with ack timeout and direct register write.
// Define MDR_BYPASS_EN to drop the WB state and MDR and write MemData straight into the register file.
module mem_load_regfile #(
  parameter int WIDTH   = 16,
  parameter int REGS    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             IRWrite,
  input  logic [WIDTH-1:0] IRData,
  input  logic [WIDTH-1:0] AData,
  input  logic             RegWrite,
  input  logic             Start,
  output logic             MemReq,
  output logic [WIDTH-1:0] MemAddr,
  input  logic             MemAck,
  input  logic [WIDTH-1:0] MemData,
  output logic [WIDTH-1:0] AccOut,
  output logic             Busy,
  output logic             Done,
  output logic             Err
);

  localparam int REG_AW = $clog2(REGS);
  localparam int CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WB} state_t;

  state_t            state;
  logic [WIDTH-1:0]  ir;
  logic [WIDTH-1:0]  regs [REGS];
  logic [REG_AW-1:0] rd_q;
  logic [CW-1:0]     cnt;
`ifndef MDR_BYPASS_EN
  logic [WIDTH-1:0]  mdr;
`endif

  logic [REG_AW-1:0] ir_rd;
  logic [WIDTH-1:0]  offset;

  assign ir_rd  = ir[REG_AW-1:0];
  assign offset = {{REG_AW{1'b0}}, ir[WIDTH-1:REG_AW]};
  assign AccOut = regs[ir_rd];
  assign Busy   = (state != S_IDLE);

  // Commands are only honoured in IDLE; the destination register is frozen at Start.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state   <= S_IDLE;
      ir      <= '0;
      rd_q    <= '0;
      cnt     <= '0;
      MemReq  <= 1'b0;
      MemAddr <= '0;
      Done    <= 1'b0;
      Err     <= 1'b0;
`ifndef MDR_BYPASS_EN
      mdr     <= '0;
`endif
      for (int i = 0; i < REGS; i++) regs[i] <= '0;
    end else begin
      Done <= 1'b0;
      Err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (IRWrite)  ir <= IRData;
          if (RegWrite) regs[ir_rd] <= AData;
          if (Start) begin
            MemAddr <= AData + offset;
            MemReq  <= 1'b1;
            cnt     <= '0;
            rd_q    <= ir_rd;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (MemAck) begin
            MemReq <= 1'b0;
`ifdef MDR_BYPASS_EN
            regs[rd_q] <= MemData;
            Done       <= 1'b1;
            state      <= S_IDLE;
`else
            mdr   <= MemData;
            state <= S_WB;
`endif
          end else begin
            cnt <= cnt + 1'b1;
            // An ack on the last permitted edge is taken above, so it beats the timeout.
            if (TIMEOUT != 0 && cnt == CNT_LAST) begin
              MemReq <= 1'b0;
              Err    <= 1'b1;
              state  <= S_IDLE;
            end
          end
        end
        S_WB: begin
`ifndef MDR_BYPASS_EN
          regs[rd_q] <= mdr;
          Done       <= 1'b1;
`endif
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_load_regfile.sv
// Randomised self-checking bench for mem_load_regfile against a transaction-level model.
// Honours MDR_BYPASS_EN to expect the shorter load latency.
module tb_mem_load_regfile;

  localparam int WIDTH   = 16;
  localparam int REGS    = 4;
  localparam int TIMEOUT = 15;
`ifdef MDR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             Reset;
  logic             IRWrite;
  logic [WIDTH-1:0] IRData;
  logic [WIDTH-1:0] AData;
  logic             RegWrite;
  logic             Start;
  logic             MemReq;
  logic [WIDTH-1:0] MemAddr;
  logic             MemAck;
  logic [WIDTH-1:0] MemData;
  logic [WIDTH-1:0] AccOut;
  logic             Busy;
  logic             Done;
  logic             Err;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] m_ir;
  logic [WIDTH-1:0] m_regs [REGS];

  mem_load_regfile #(.WIDTH(WIDTH), .REGS(REGS), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .Reset(Reset), .IRWrite(IRWrite), .IRData(IRData), .AData(AData),
    .RegWrite(RegWrite), .Start(Start), .MemReq(MemReq), .MemAddr(MemAddr),
    .MemAck(MemAck), .MemData(MemData), .AccOut(AccOut), .Busy(Busy),
    .Done(Done), .Err(Err)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] expAcc();
    return m_regs[m_ir[1:0]];
  endfunction

  task automatic modelReset();
    m_ir = '0;
    for (int i = 0; i < REGS; i++) m_regs[i] = '0;
  endtask

  // Drives one set of inputs across a single rising edge, then returns 1 time unit after it.
  task automatic applyStimulus(input bit irw, input logic [WIDTH-1:0] ird, input bit rw,
                               input bit st, input logic [WIDTH-1:0] ad, input bit ack,
                               input logic [WIDTH-1:0] md);
    IRWrite = irw; IRData = ird; RegWrite = rw; Start = st;
    AData = ad; MemAck = ack; MemData = md;
    @(posedge CLK);
    #1;
    IRWrite = 1'b0; RegWrite = 1'b0; Start = 1'b0; MemAck = 1'b0;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic doIrWrite(input logic [WIDTH-1:0] v);
    applyStimulus(1'b1, v, 1'b0, 1'b0, '0, 1'b0, '0);
    m_ir = v;
    checkOutput("irw_acc", AccOut, expAcc());
    checkOutput("irw_busy", Busy, 0);
  endtask

  task automatic doRegWrite(input logic [WIDTH-1:0] v);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, v, 1'b0, '0);
    m_regs[m_ir[1:0]] = v;
    checkOutput("rw_acc", AccOut, expAcc());
  endtask

  // One load transaction; ack_at is the WAIT edge number that carries MemAck.
  task automatic doLoad(input logic [WIDTH-1:0] base, input int ack_at, input logic [WIDTH-1:0] data,
                        input bit noise, input bit with_irw, input logic [WIDTH-1:0] irw_val,
                        input bit with_rw, input bit b2b);
    logic [1:0]       rd;
    logic [WIDTH-1:0] addr;
    bit               timed_out;
    int               last;
    bit               n_irw, n_rw, n_st;
    rd        = m_ir[1:0];
    addr      = base + (m_ir >> 2);
    timed_out = (TIMEOUT != 0) && (ack_at > TIMEOUT);
    last      = timed_out ? TIMEOUT : ack_at;

    applyStimulus(with_irw, irw_val, with_rw, 1'b1, base, 1'b0, '0);
    if (with_rw)  m_regs[rd] = base;
    if (with_irw) m_ir = irw_val;
    checkOutput("start_req", MemReq, 1);
    checkOutput("start_addr", MemAddr, addr);
    checkOutput("start_busy", Busy, 1);
    checkOutput("start_acc", AccOut, expAcc());

    for (int e = 1; e <= last; e++) begin
      n_irw = noise & $urandom_range(0, 1);
      n_rw  = noise & $urandom_range(0, 1);
      n_st  = noise & $urandom_range(0, 1);
      applyStimulus(n_irw, WIDTH'($urandom), n_rw, n_st, WIDTH'($urandom),
                    (e == ack_at), (e == ack_at) ? data : WIDTH'($urandom));
      if (e < last) begin
        checkOutput("wait_req", MemReq, 1);
        checkOutput("wait_addr", MemAddr, addr);
        checkOutput("wait_busy", Busy, 1);
        checkOutput("wait_done", Done, 0);
        checkOutput("wait_err", Err, 0);
        checkOutput("wait_acc", AccOut, expAcc());
      end
    end

    if (timed_out) begin
      checkOutput("to_err", Err, 1);
      checkOutput("to_req", MemReq, 0);
      checkOutput("to_busy", Busy, 0);
      checkOutput("to_done", Done, 0);
      checkOutput("to_acc", AccOut, expAcc());
    end else begin
      if (!BYPASS) begin
        checkOutput("ack_req", MemReq, 0);
        checkOutput("ack_busy", Busy, 1);
        checkOutput("ack_done", Done, 0);
        checkOutput("ack_acc", AccOut, expAcc());
        n_irw = noise & $urandom_range(0, 1);
        n_rw  = noise & $urandom_range(0, 1);
        n_st  = noise & $urandom_range(0, 1);
        applyStimulus(n_irw, WIDTH'($urandom), n_rw, n_st, WIDTH'($urandom),
                      noise & $urandom_range(0, 1), WIDTH'($urandom));
      end
      m_regs[rd] = data;
      checkOutput("done_pulse", Done, 1);
      checkOutput("done_busy", Busy, 0);
      checkOutput("done_err", Err, 0);
      checkOutput("done_acc", AccOut, expAcc());
    end

    if (!b2b) begin
      idleCycle();
      checkOutput("post_done", Done, 0);
      checkOutput("post_err", Err, 0);
      checkOutput("post_req", MemReq, 0);
    end
  endtask

  initial begin
    Reset = 1'b1; IRWrite = 0; IRData = '0; AData = '0; RegWrite = 0;
    Start = 0; MemAck = 0; MemData = '0;
    modelReset();
    #12;
    checkOutput("rst_acc", AccOut, 0);
    checkOutput("rst_req", MemReq, 0);
    checkOutput("rst_addr", MemAddr, 0);
    checkOutput("rst_busy", Busy, 0);
    checkOutput("rst_done", Done, 0);
    checkOutput("rst_err", Err, 0);
    Reset = 1'b0;
    @(negedge CLK);

    $display("[TB] async reset clears AccOut");
    doIrWrite(16'h0001);
    doRegWrite(16'h0001);
    checkOutput("t1_acc", AccOut, 16'h0001);
    @(negedge CLK);
    Reset = 1'b1;
    #1;
    modelReset();
    checkOutput("t1_async_acc", AccOut, 0);
    Reset = 1'b0;
    @(negedge CLK);

    $display("[TB] basic load, address wrap, timeout");
    doIrWrite(16'h0142);
    doLoad(16'h1000, 3, 16'hBEEF, 0, 0, '0, 0, 0);
    checkOutput("t2_acc", AccOut, 16'hBEEF);
    doLoad(16'hFFF0, 1, 16'h5A5A, 0, 0, '0, 0, 0);
    doRegWrite(16'h7777);
    doLoad(16'h2000, TIMEOUT + 1, 16'h0BAD, 0, 0, '0, 0, 0);
    checkOutput("t4_reg_kept", AccOut, 16'h7777);
    doLoad(16'h2000, TIMEOUT, 16'hC0DE, 0, 0, '0, 0, 0);
    checkOutput("ack_beats_to", AccOut, 16'hC0DE);

    $display("[TB] busy ignore and same-edge commands");
    doLoad(16'h3000, 4, 16'h1234, 1, 0, '0, 0, 0);
    doLoad(16'h0100, 2, 16'h4321, 0, 1, 16'h0003, 1, 1);
    doLoad(16'h0200, 1, 16'h9999, 0, 0, '0, 0, 0);

    $display("[TB] reset during WAIT");
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 16'h4000, 1'b0, '0);
    idleCycle();
    @(negedge CLK);
    Reset = 1'b1;
    #1;
    modelReset();
    checkOutput("midrst_req", MemReq, 0);
    checkOutput("midrst_busy", Busy, 0);
    checkOutput("midrst_acc", AccOut, 0);
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 16'hFFFF);
      checkOutput("midrst_done", Done, 0);
      checkOutput("midrst_noreq", MemReq, 0);
    end

    $display("[TB] random transactions");
    for (int n = 0; n < 200; n++) begin
      int op;
      op = $urandom_range(0, 99);
      if (op < 20)      doIrWrite(WIDTH'($urandom));
      else if (op < 40) doRegWrite(WIDTH'($urandom));
      else              doLoad(WIDTH'($urandom), $urandom_range(1, TIMEOUT + 2), WIDTH'($urandom),
                               $urandom_range(0, 1), $urandom_range(0, 3) == 0, WIDTH'($urandom),
                               $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
    end
    idleCycle();
    checkOutput("final_acc", AccOut, expAcc());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
